// File: rtl/bp_cfg_responder.sv
// bp_cfg_responder
//   Responder end of the per-core config bus. Commands are filtered on core id
//   (the all-ones id is a broadcast), writes update local config registers, and
//   each accepted read produces exactly one response over a valid/yumi handshake.
//   The registers drive the freeze and cache/CCE mode controls of one core tile.
//
// Ports
//   clk_i, reset_i   clock, synchronous active-high reset
//   my_core_id_i     this tile's core id (static after reset)
//   cmd_v_i          command valid; a transfer happens on cmd_v_i & cmd_ready_o
//   cmd_ready_o      responder can accept a command
//   cmd_we_i         1 = write, 0 = read
//   cmd_core_i       target core id (all-ones = broadcast)
//   cmd_addr_i       register address
//   cmd_data_i       write data
//   resp_v_o         read response valid
//   resp_yumi_i      consumer takes the response (legal only while resp_v_o)
//   resp_data_o      read data, zero-extended
//   resp_err_o       unmapped address or broadcast read
//   freeze_o         core held frozen
//   icache_mode_o    I$ mode
//   dcache_mode_o    D$ mode
//   cce_mode_o       0 = uncached, 1 = normal
module bp_cfg_responder #(
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cfg_core_width_p-1:0] my_core_id_i,
  input  logic                        cmd_v_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_we_i,
  input  logic [cfg_core_width_p-1:0] cmd_core_i,
  input  logic [cfg_addr_width_p-1:0] cmd_addr_i,
  input  logic [cfg_data_width_p-1:0] cmd_data_i,
  output logic                        resp_v_o,
  input  logic                        resp_yumi_i,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,
  output logic                        freeze_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o
);

  localparam logic [cfg_addr_width_p-1:0] addr_freeze  = cfg_addr_width_p'(16'h0000);
  localparam logic [cfg_addr_width_p-1:0] addr_icache  = cfg_addr_width_p'(16'h0002);
  localparam logic [cfg_addr_width_p-1:0] addr_dcache  = cfg_addr_width_p'(16'h0003);
  localparam logic [cfg_addr_width_p-1:0] addr_cce     = cfg_addr_width_p'(16'h0004);
  localparam logic [cfg_addr_width_p-1:0] addr_scratch = cfg_addr_width_p'(16'h0005);
  localparam logic [cfg_addr_width_p-1:0] addr_wrcnt   = cfg_addr_width_p'(16'h0006);

  typedef enum logic {e_ready, e_resp} state_e;

  state_e state_r, state_n;

  logic                        freeze_r;
  logic [1:0]                  icache_mode_r;
  logic [1:0]                  dcache_mode_r;
  logic                        cce_mode_r;
  logic [cfg_data_width_p-1:0] scratch_r;
  logic [cfg_data_width_p-1:0] wr_count_r;
  logic [cfg_data_width_p-1:0] resp_data_r;
  logic                        resp_err_r;

  logic                        cmd_fire;
  logic                        is_bcast;
  logic                        id_match;
  logic                        wr_en;
  logic                        rd_en;
  logic                        addr_rw;
  logic                        rd_hit;
  logic [cfg_data_width_p-1:0] rd_data;

  assign is_bcast = &cmd_core_i;
  assign id_match = (cmd_core_i == my_core_id_i) | is_bcast;
  assign cmd_fire = cmd_v_i & cmd_ready_o;
  // Writes to the read-only counter or to holes are dropped without counting.
  assign wr_en    = cmd_fire & id_match & cmd_we_i & addr_rw;
  assign rd_en    = cmd_fire & id_match & ~cmd_we_i;

  // Address decode: read mux plus writable-register flag.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    addr_rw = 1'b1;
    case (cmd_addr_i)
      addr_freeze:  rd_data[0]   = freeze_r;
      addr_icache:  rd_data[1:0] = icache_mode_r;
      addr_dcache:  rd_data[1:0] = dcache_mode_r;
      addr_cce:     rd_data[0]   = cce_mode_r;
      addr_scratch: rd_data      = scratch_r;
      addr_wrcnt: begin
        rd_data = wr_count_r;
        addr_rw = 1'b0;
      end
      default: begin
        rd_hit  = 1'b0;
        addr_rw = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_n     = state_r;
    cmd_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (state_r)
      e_ready: begin
        cmd_ready_o = 1'b1;
        if (rd_en) state_n = e_resp;
      end
      e_resp: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= e_ready;
      freeze_r      <= 1'b1;
      icache_mode_r <= 2'b00;
      dcache_mode_r <= 2'b00;
      cce_mode_r    <= 1'b0;
      scratch_r     <= '0;
      wr_count_r    <= '0;
      resp_data_r   <= '0;
      resp_err_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      if (wr_en) begin
        case (cmd_addr_i)
          addr_freeze:  freeze_r      <= cmd_data_i[0];
          addr_icache:  icache_mode_r <= cmd_data_i[1:0];
          addr_dcache:  dcache_mode_r <= cmd_data_i[1:0];
          addr_cce:     cce_mode_r    <= cmd_data_i[0];
          addr_scratch: scratch_r     <= cmd_data_i;
          default: ;
        endcase
        wr_count_r <= wr_count_r + 1'b1;
      end
      // A broadcast read would collide with other tiles' responses, so it
      // returns an error with zero data regardless of address.
      if (rd_en) begin
        resp_data_r <= is_bcast ? '0 : rd_data;
        resp_err_r  <= is_bcast | ~rd_hit;
      end
    end
  end

  assign resp_data_o   = resp_data_r;
  assign resp_err_o    = resp_err_r;
  assign freeze_o      = freeze_r;
  assign icache_mode_o = icache_mode_r;
  assign dcache_mode_o = dcache_mode_r;
  assign cce_mode_o    = cce_mode_r;

`ifndef SYNTHESIS
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    resp_yumi_i |-> resp_v_o)
    else $error("resp_yumi_i asserted while resp_v_o is low");
`endif

endmodule

// File: tb/tb_bp_cfg_responder.sv
module tb_bp_cfg_responder;

  localparam logic [7:0] my_id = 8'h2A;
  localparam logic [7:0] bcast = 8'hFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_v = 1'b0;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_core = '0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        resp_yumi = 1'b0;

  logic        cmd_ready, resp_v, resp_err, freeze, cce;
  logic [31:0] resp_data;
  logic [1:0]  icm, dcm;

  // Narrow-data instance so the write counter can be driven through its wrap.
  logic        v8 = 1'b0;
  logic        yumi8 = 1'b0;
  logic        ready8, rv8, rerr8, frz8, cce8;
  logic [7:0]  rdata8;
  logic [1:0]  icm8, dcm8;

  always #5 clk = ~clk;

  bp_cfg_responder dut (
    .clk_i(clk), .reset_i(reset), .my_core_id_i(my_id),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_core_i(cmd_core), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .freeze_o(freeze), .icache_mode_o(icm),
    .dcache_mode_o(dcm), .cce_mode_o(cce)
  );

  bp_cfg_responder #(.cfg_data_width_p(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .my_core_id_i(my_id),
    .cmd_v_i(v8), .cmd_ready_o(ready8), .cmd_we_i(cmd_we),
    .cmd_core_i(cmd_core), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data[7:0]),
    .resp_v_o(rv8), .resp_yumi_i(yumi8), .resp_data_o(rdata8),
    .resp_err_o(rerr8), .freeze_o(frz8), .icache_mode_o(icm8),
    .dcache_mode_o(dcm8), .cce_mode_o(cce8)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference register file, indexed by address; holes are simply absent.
  logic [31:0] m_reg [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_reg[0] = 32'd1;
  endtask

  function automatic bit is_rw(input logic [15:0] a);
    return (a == 16'd0) || (a >= 16'd2 && a <= 16'd5);
  endfunction

  function automatic bit is_mapped(input logic [15:0] a);
    return is_rw(a) || a == 16'd6;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d);
    if (is_rw(a)) begin
      case (a)
        16'd0, 16'd4: m_reg[a[2:0]] = {31'd0, d[0]};
        16'd2, 16'd3: m_reg[a[2:0]] = {30'd0, d[1:0]};
        default:      m_reg[a[2:0]] = d;
      endcase
      m_reg[6] = m_reg[6] + 32'd1;
    end
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, ".freeze"}, {31'd0, freeze}, m_reg[0]);
    check({tag, ".icache"}, {30'd0, icm}, m_reg[2]);
    check({tag, ".dcache"}, {30'd0, dcm}, m_reg[3]);
    check({tag, ".cce"}, {31'd0, cce}, m_reg[4]);
  endtask

  // Called 1 time unit after a rising edge; issues one command and completes it.
  task automatic do_cmd(input logic we, input logic [7:0] core,
                        input logic [15:0] addr, input logic [31:0] data);
    bit          m;
    logic [31:0] ed;
    logic        ee;
    m = (core == my_id) || (core == bcast);
    check("cmd_ready_pre", {31'd0, cmd_ready}, 32'd1);
    cmd_v = 1'b1; cmd_we = we; cmd_core = core; cmd_addr = addr; cmd_data = data;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    if (!we && m) begin
      ee = (core == bcast) || !is_mapped(addr);
      ed = ee ? 32'd0 : m_reg[addr[2:0]];
      check("resp_v", {31'd0, resp_v}, 32'd1);
      check("resp_data", resp_data, ed);
      check("resp_err", {31'd0, resp_err}, {31'd0, ee});
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      resp_yumi = 1'b1;
      @(posedge clk); #1;
      resp_yumi = 1'b0;
      check("ready_after_yumi", {31'd0, cmd_ready}, 32'd1);
      check("resp_v_after_yumi", {31'd0, resp_v}, 32'd0);
    end else begin
      if (we && m) model_write(addr, data);
      check("resp_v_idle", {31'd0, resp_v}, 32'd0);
      check_ctrl("ctrl");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rc;
    logic [15:0] ra;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst.resp_v", {31'd0, resp_v}, 32'd0);
    check("rst.resp_data", resp_data, 32'd0);
    check("rst.resp_err", {31'd0, resp_err}, 32'd0);
    check_ctrl("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    do_cmd(1'b0, my_id, 16'h0000, 32'd0);
    do_cmd(1'b1, my_id, 16'h0000, 32'd0);
    do_cmd(1'b0, my_id, 16'h0006, 32'd0);
    do_cmd(1'b1, 8'h11, 16'h0005, 32'hDEADBEEF);
    do_cmd(1'b0, my_id, 16'h0005, 32'd0);
    do_cmd(1'b0, my_id, 16'h0006, 32'd0);
    do_cmd(1'b1, bcast, 16'h0002, 32'd3);
    do_cmd(1'b0, bcast, 16'h0002, 32'd0);
    do_cmd(1'b1, my_id, 16'h0006, 32'h55);
    do_cmd(1'b1, my_id, 16'h0001, 32'h55);
    do_cmd(1'b0, my_id, 16'h0006, 32'd0);

    // Unmapped read held for 5 cycles without yumi
    cmd_v = 1'b1; cmd_we = 1'b0; cmd_core = my_id; cmd_addr = 16'h0007;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold.resp_v", {31'd0, resp_v}, 32'd1);
      check("hold.resp_data", resp_data, 32'd0);
      check("hold.resp_err", {31'd0, resp_err}, 32'd1);
      check("hold.cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
    check("hold.ready_after", {31'd0, cmd_ready}, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    rc = my_id;
        2:       rc = bcast;
        default: rc = 8'($urandom_range(0, 8'h29));
      endcase
      ra = 16'($urandom_range(0, 7));
      do_cmd(1'($urandom_range(0, 1)), rc, ra, $urandom);
    end

    // Reset while a response is pending
    do_cmd(1'b1, my_id, 16'h0000, 32'd0);
    cmd_v = 1'b1; cmd_we = 1'b0; cmd_core = my_id; cmd_addr = 16'h0005;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    check("rstpend.resp_v_before", {31'd0, resp_v}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("rstpend.resp_v", {31'd0, resp_v}, 32'd0);
    check("rstpend.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rstpend.resp_data", resp_data, 32'd0);
    check_ctrl("rstpend");
    reset = 1'b0;
    @(posedge clk); #1;
    do_cmd(1'b0, my_id, 16'h0006, 32'd0);

    // Counter wrap on the 8-bit instance: 255 writes, then one more
    v8 = 1'b1; cmd_we = 1'b1; cmd_core = my_id; cmd_addr = 16'h0005;
    for (int i = 0; i < 255; i++) begin
      cmd_data = $urandom;
      @(posedge clk); #1;
    end
    cmd_we = 1'b0; cmd_addr = 16'h0006;
    @(posedge clk); #1;
    v8 = 1'b0;
    check("wrap.resp_v_max", {31'd0, rv8}, 32'd1);
    check("wrap.count_max", {24'd0, rdata8}, 32'hFF);
    yumi8 = 1'b1;
    @(posedge clk); #1;
    yumi8 = 1'b0;
    v8 = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0004; cmd_data = 32'd1;
    @(posedge clk); #1;
    cmd_we = 1'b0; cmd_addr = 16'h0006;
    @(posedge clk); #1;
    v8 = 1'b0;
    check("wrap.cce8", {31'd0, cce8}, 32'd1);
    check("wrap.count_zero", {24'd0, rdata8}, 32'h00);
    check("wrap.err", {31'd0, rerr8}, 32'd0);
    yumi8 = 1'b1;
    @(posedge clk); #1;
    yumi8 = 1'b0;
    check("wrap.ready8", {31'd0, ready8}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
